// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares a single-ported 256 x 64-bit data memory between two requesters
// (req0: core load/store path, req1: debug/loader port). Requests are
// granted round-robin, then each transaction goes through a fixed
// IDLE -> ACCESS -> RESP sequence, so one transaction completes every three
// cycles at most.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake (N = 0, 1)
//   reqN_we/addr/wdata          request kind, word address, write data
//   rspN_valid                  one-cycle response pulse
//   rspN_rdata                  read data (0 for writes and errors)
//   rspN_err                    address was out of range
//   mem_read/mem_write          memory enables, only active during ACCESS
//   mem_address/mem_write_data  memory address and write data
//   mem_read_data               combinational read data from the memory
module dmem_arbiter #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [63:0] req0_addr,
    input  logic [63:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [63:0] req1_addr,
    input  logic [63:0] req1_wdata,
    output logic        rsp0_valid,
    output logic [63:0] rsp0_rdata,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [63:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);

    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    logic        last_grant;   // id of the requester granted most recently
    logic        lat_id;
    logic        lat_we;
    logic        lat_err;

    logic        grant0;
    logic        grant1;
    logic        handshake;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_err;
    logic        rd_ok;

    // A lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    // Ready is held low while reset is asserted so every output reads 0 then.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign handshake  = req0_ready | req1_ready;

    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
    // Full 64-bit compare: high address bits are never dropped or wrapped.
    assign sel_err   = (sel_addr >= DEPTH_W);

    assign rd_ok = ~lat_err & ~lat_we;

    // The memory-side outputs are loaded on the handshake edge so they are
    // valid for exactly the ACCESS cycle; the async reset clears them
    // immediately, which keeps a write from committing when reset hits
    // mid-ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            lat_id         <= 1'b0;
            lat_we         <= 1'b0;
            lat_err        <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            rsp0_valid     <= 1'b0;
            rsp0_rdata     <= '0;
            rsp0_err       <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp1_rdata     <= '0;
            rsp1_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state          <= ACCESS;
                        lat_id         <= grant1;
                        last_grant     <= grant1;
                        lat_we         <= sel_we;
                        lat_err        <= sel_err;
                        mem_read       <= ~sel_err & ~sel_we;
                        mem_write      <= ~sel_err & sel_we;
                        mem_address    <= sel_err ? '0 : sel_addr;
                        mem_write_data <= (~sel_err & sel_we) ? sel_wdata : '0;
                    end
                end
                ACCESS: begin
                    state          <= RESP;
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b0;
                    mem_address    <= '0;
                    mem_write_data <= '0;
                    rsp0_valid     <= ~lat_id;
                    rsp1_valid     <= lat_id;
                    rsp0_err       <= ~lat_id & lat_err;
                    rsp1_err       <= lat_id & lat_err;
                    rsp0_rdata     <= (~lat_id & rd_ok) ? mem_read_data : '0;
                    rsp1_rdata     <= (lat_id & rd_ok) ? mem_read_data : '0;
                end
                RESP: begin
                    state      <= IDLE;
                    rsp0_valid <= 1'b0;
                    rsp0_rdata <= '0;
                    rsp0_err   <= 1'b0;
                    rsp1_valid <= 1'b0;
                    rsp1_rdata <= '0;
                    rsp1_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: models the 256 x 64 memory, drives both
// requesters, and checks responses against a queue-based reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [63:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [63:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [63:0] rsp0_rdata, rsp1_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_address, mem_write_data, mem_read_data;

    logic [63:0] mem     [0:255];  // the physical memory the DUT drives
    logic [63:0] ref_mem [0:255];  // expected contents, updated per transaction

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } grant_t;

    exp_t   q0[$];
    exp_t   q1[$];
    grant_t glog[$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = mem[mem_address[7:0]];
    always @(posedge clk) if (mem_write) mem[mem_address[7:0]] <= mem_write_data;

    dmem_arbiter #(.DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name, input string why);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (t=%0t)", name, why, $time);
    endfunction

    function automatic void chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
        chk({tag, "_rspflags"}, 64'({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}), 64'd0);
        chk({tag, "_rdata"}, rsp0_rdata | rsp1_rdata, 64'd0);
        chk({tag, "_memen"}, 64'({mem_read, mem_write}), 64'd0);
        chk({tag, "_memdata"}, mem_address | mem_write_data, 64'd0);
    endfunction

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    // Present one request (valid left high on return), wait for the
    // handshake, record the expected response, and check the ACCESS cycle.
    task automatic issue(input int p, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata);
        int     waited;
        logic   got;
        logic   oor;
        exp_t   e;
        grant_t g;
        waited = 0;
        got    = 1'b0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, addr, wdata);
        while (!got && waited < 50) begin
            @(negedge clk);
            if (rst_n && rdy(p)) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            fail_now($sformatf("handshake_p%0d", p), "no ready within 50 cycles");
            drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
            return;
        end
        oor    = (addr >= 64'd256);
        e.cyc  = cyc + 2;
        e.err  = oor;
        e.data = 64'd0;
        if (!oor) begin
            if (we) ref_mem[addr[7:0]] = wdata;
            else    e.data = ref_mem[addr[7:0]];
        end
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        g.id  = p;
        g.cyc = cyc;
        glog.push_back(g);
        @(negedge clk);
        chk($sformatf("acc_rd_p%0d", p), 64'(mem_read), 64'(!oor && !we));
        chk($sformatf("acc_wr_p%0d", p), 64'(mem_write), 64'(!oor && we));
        chk($sformatf("acc_addr_p%0d", p), mem_address, oor ? 64'd0 : addr);
        chk($sformatf("acc_wdata_p%0d", p), mem_write_data, (!oor && we) ? wdata : 64'd0);
    endtask

    task automatic rand_stream(input int p, input int n);
        logic        we;
        logic [63:0] addr;
        int          k;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 9));
            if (k < 6)      addr = 64'($urandom_range(0, 15));
            else if (k < 8) addr = 64'($urandom_range(248, 255));
            else if (k < 9) addr = 64'd256 + 64'($urandom_range(0, 40));
            else            addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            issue(p, we, addr, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) begin
                drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
                repeat ($urandom_range(1, 4)) @(posedge clk);
            end
        end
        drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    // Scoreboard monitor: pops an expectation for every response pulse.
    always @(negedge clk) begin
        exp_t e;
        chk("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
        chk("rsp_onehot", 64'(rsp0_valid & rsp1_valid), 64'd0);
        if (rsp0_valid) begin
            if (q0.size() == 0) fail_now("rsp0_spurious", "response with nothing outstanding");
            else begin
                e = q0.pop_front();
                chk("rsp0_rdata", rsp0_rdata, e.data);
                chk("rsp0_err", 64'(rsp0_err), 64'(e.err));
                chk("rsp0_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("rsp0_quiet", rsp0_rdata | 64'(rsp0_err), 64'd0);
        end
        if (rsp1_valid) begin
            if (q1.size() == 0) fail_now("rsp1_spurious", "response with nothing outstanding");
            else begin
                e = q1.pop_front();
                chk("rsp1_rdata", rsp1_rdata, e.data);
                chk("rsp1_err", 64'(rsp1_err), 64'(e.err));
                chk("rsp1_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("rsp1_quiet", rsp1_rdata | 64'(rsp1_err), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          rel_cyc;
        logic [63:0] v;
        logic [63:0] m0;
        logic [63:0] wval;
        rel_cyc = 0;
        rst_n   = 1'b0;
        drive(0, 1'b1, 1'b0, 64'd3, 64'd0);
        drive(1, 1'b1, 1'b0, 64'd4, 64'd0);
        for (int i = 0; i < 256; i++) begin
            v = {$urandom, $urandom};
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[0] = 64'h0123_4567_89AB_CDEF; ref_mem[0] = 64'h0123_4567_89AB_CDEF;
        mem[5] = 64'h0000_0000_0000_DEAD; ref_mem[5] = 64'h0000_0000_0000_DEAD;
        mem[7] = 64'h55;                  ref_mem[7] = 64'h55;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // Contention straight out of reset: grants 0,1,0,1 every 3 cycles.
        glog.delete();
        fork
            begin
                issue(0, 1'b0, 64'($urandom_range(8, 200)), 64'd0);
                issue(0, 1'b0, 64'($urandom_range(8, 200)), 64'd0);
                drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
            end
            begin
                issue(1, 1'b0, 64'($urandom_range(8, 200)), 64'd0);
                issue(1, 1'b0, 64'($urandom_range(8, 200)), 64'd0);
                drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
            end
            begin
                @(posedge clk); #1;
                rst_n   = 1'b1;
                rel_cyc = cyc;
            end
        join
        chk("cont_count", 64'(glog.size()), 64'd4);
        for (int i = 0; i < glog.size(); i++) begin
            chk($sformatf("cont_id%0d", i), 64'(glog[i].id), 64'(i % 2));
            chk($sformatf("cont_cyc%0d", i), 64'(glog[i].cyc), 64'(rel_cyc + 3 * i));
        end
        repeat (3) @(negedge clk);

        // Single read of the preloaded word.
        issue(0, 1'b0, 64'd5, 64'd0);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        chk("read5_valid", 64'({rsp0_valid, rsp1_valid}), 64'b10);
        chk("read5_data", rsp0_rdata, 64'h0000_0000_0000_DEAD);

        // Write then read back the top legal address.
        wval = 64'h1234_5678_9ABC_DEF0;
        issue(1, 1'b1, 64'd255, wval);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        chk("wr255_rsp", 64'({rsp1_valid, rsp1_err}), 64'b10);
        chk("wr255_rdata", rsp1_rdata, 64'd0);
        issue(1, 1'b0, 64'd255, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        chk("rd255_data", rsp1_rdata, wval);

        // Out-of-range accesses, including one that only differs in high bits.
        m0 = mem[0];
        issue(0, 1'b1, 64'd256, 64'hFF);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        chk("oor256_err", 64'({rsp0_valid, rsp0_err}), 64'b11);
        issue(0, 1'b0, 64'd300, 64'd0);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        chk("oor300_err", 64'({rsp0_valid, rsp0_err}), 64'b11);
        chk("oor300_rdata", rsp0_rdata, 64'd0);
        issue(0, 1'b0, 64'h1000_0000_0000_0005, 64'd0);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        chk("oor_high_err", 64'(rsp0_err), 64'd1);
        chk("no_wrap", mem[0], m0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a write's ACCESS cycle.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 64'd7, 64'hAA);
        @(negedge clk);
        chk("rst_ready", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        chk("rst_acc_wr", 64'(mem_write), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_no_commit", mem[7], 64'h55);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First tie after reset goes to requester 0.
        glog.delete();
        fork
            begin
                issue(0, 1'b0, 64'd7, 64'd0);
                drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
            end
            begin
                issue(1, 1'b0, 64'd9, 64'd0);
                drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
            end
        join
        chk("tie_count", 64'(glog.size()), 64'd2);
        if (glog.size() >= 2) begin
            chk("tie_first", 64'(glog[0].id), 64'd0);
            chk("tie_second", 64'(glog[1].id), 64'd1);
        end
        repeat (3) @(negedge clk);

        // Back-to-back reads from requester 1 alone.
        glog.delete();
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 64'($urandom_range(0, 255)), 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("b2b_count", 64'(glog.size()), 64'd4);
        for (int i = 1; i < glog.size(); i++) begin
            chk($sformatf("b2b_gap%0d", i), 64'(glog[i].cyc - glog[i-1].cyc), 64'd3);
            chk($sformatf("b2b_id%0d", i), 64'(glog[i].id), 64'd1);
        end
        repeat (3) @(negedge clk);

        // Random traffic from both requesters at once.
        fork
            rand_stream(0, 30);
            rand_stream(1, 30);
        join
        repeat (6) @(negedge clk);
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported 64-bit data memory (256 × 64-bit, word-addressed, combinational read, write on `clk` rising edge). It shares the memory between requester 0 (core load/store path) and requester 1 (debug/loader port) using a valid/ready request handshake and a one-cycle response pulse. Arbitration is round-robin, and each transaction is sequenced through a fixed three-state FSM. The block sits between both requesters and the memory's `mem_read`/`mem_write`/`address`/`write_data`/`read_data` pins.

## Interface
- `DEPTH`, default 256: number of memory words; addresses ≥ DEPTH are rejected.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `reqN_valid` in 1 (N=0,1): request present.
- `reqN_ready` out 1: request accepted this cycle.
- `reqN_we` in 1: 1 = write, 0 = read.
- `reqN_addr` in 64: word address.
- `reqN_wdata` in 64: write data.
- `rspN_valid` out 1: one-cycle response pulse.
- `rspN_rdata` out 64: read data; 0 for writes and errors.
- `rspN_err` out 1: address out of range; valid with `rspN_valid`.
- `mem_read` out 1: to memory read enable.
- `mem_write` out 1: to memory write enable.
- `mem_address` out 64: to memory address.
- `mem_write_data` out 64: to memory write data.
- `mem_read_data` in 64: from memory read data (combinational).

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - Grant is combinational from valids.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` = (state==IDLE) & grantN. At most one ready is high.
  - On handshake (valid & ready), latch id, we, addr, wdata and the range flag (addr ≥ DEPTH), update `last_grant`, and go to ACCESS.
  - With no valid requests, stay in IDLE.
- ACCESS (exactly one cycle):
  - `mem_address` = latched addr.
  - If in range: `mem_read` = ~we and `mem_write` = we; `mem_write_data` = wdata when writing, else 0.
  - If out of range: `mem_read` = `mem_write` = 0; `mem_address` and `mem_write_data` = 0.
  - At the clock edge, the memory commits any write, and the block registers `mem_read_data` into the response register for in-range reads (0 otherwise). Then go to RESP.
- RESP (exactly one cycle):
  - `rspN_valid` = 1 for the latched id only.
  - `rspN_rdata` = registered data; `rspN_err` = range flag.
  - Next state is IDLE.
- Outside ACCESS, all `mem_*` outputs are 0. Outside RESP, `rsp*_valid` and `rsp*_err` are 0 and `rsp*_rdata` is 0.
- Requester rules: once `reqN_valid` rises, the requester holds valid, we, addr and wdata stable until ready. Valid must not depend on ready.
- Reset values:
  - All outputs are 0 and state is IDLE.
  - The latched request, response data and flag are all 0.
  - `last_grant` is 1.
- Reset mid-operation: asserting `rst_n` low in any state forces IDLE immediately and drops `mem_write` combinationally. A write in ACCESS at reset assertion is therefore not committed, and a pending response is discarded.
- Address width: the full 64-bit address is compared against DEPTH. No truncation or wrap. Address DEPTH−1 is legal and DEPTH is an error.

## Timing
- Handshake at edge of cycle T (ready high during T).
- ACCESS during T+1: memory write commits at end of T+1.
- RESP during T+2: `rspN_valid` high.
- Next handshake possible in T+3. Peak throughput is one transaction per 3 cycles.
- A read issued after a write's RESP returns the written data.
- Starvation bound: with both requesters continuously valid, grants strictly alternate. Each requester waits at most 3 cycles after its previous opportunity.

## Test plan
- Read, single requester: memory preloaded mem[5]=0x0000_0000_0000_DEAD; req0 reads addr 5 handshaking at T. Expect `mem_read`=1 and `mem_address`=5 in T+1, then `rsp0_valid`=1 and `rsp0_rdata`=0xDEAD in T+2, with `rsp1_valid`=0 throughout.
- Write then read: req1 writes 0x1234_5678_9ABC_DEF0 to addr 255; after RESP, req1 reads addr 255. Expect the write response with `rsp1_rdata`=0 and `rsp1_err`=0, then the read returning 0x1234_5678_9ABC_DEF0.
- Contention: both requesters valid continuously from reset, each doing reads. Expect grant order 0,1,0,1 with handshakes at cycles 0,3,6,9 after reset release, and never both ready high.
- Out of range: req0 writes 0xFF to addr 256, then reads addr 300. Expect `mem_write`=`mem_read`=0 in both ACCESS cycles, and `rsp0_err`=1 with `rsp0_rdata`=0 on both responses. Expect mem[0] unchanged (no wrap).
- Reset during ACCESS: req0 writes 0xAA to addr 7 (mem[7]=0x55); drive `rst_n` low mid-ACCESS before the edge. Expect `mem_write` to drop immediately, all outputs 0, mem[7] still 0x55 and no `rsp0_valid`. After release, the next tie goes to requester 0.
- Single-requester back-to-back: req1 valid with 4 consecutive reads, req0 idle. Expect handshakes every 3 cycles to req1, each with correct data.
